// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/VGA memory arbiter: state encoding and
// default parameter values.
package mem_arbiter_pkg;

    typedef enum logic {
        VGA_PRI   = 1'b0,
        CPU_FORCE = 1'b1
    } arb_state_t;

    localparam int ADDR_W_DEFAULT       = 14;
    localparam int CPU_MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU data port and the VGA framebuffer
// fetch. VGA wins by default; a CPU request starved for CPU_MAX_WAIT cycles is forced through.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int CPU_MAX_WAIT = CPU_MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [31:0]       vga_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             cpu_rd_q;
    logic             vga_rd_q;
    logic             force_cpu;

    // State, wait counter and read-owner flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= VGA_PRI;
            wait_cnt <= '0;
            cpu_rd_q <= 1'b0;
            vga_rd_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            cpu_rd_q <= cpu_gnt & ~cpu_we;
            vga_rd_q <= vga_gnt;
        end
    end

    always_comb begin
        wait_cnt_next = '0;
        if (cpu_req && !cpu_gnt) begin
            wait_cnt_next = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + 1'b1;
        end
        state_next = state;
        if (cpu_gnt) begin
            state_next = VGA_PRI;
        end else if (wait_cnt_next == CNT_MAX) begin
            state_next = CPU_FORCE;
        end
    end

    // Grants are combinational so a request is served in its own cycle.
    always_comb begin
        force_cpu = (state == CPU_FORCE);
        cpu_gnt   = ~reset & cpu_req & (~vga_req | force_cpu);
        vga_gnt   = ~reset & vga_req & ~(cpu_req & force_cpu);
        ram_en    = cpu_gnt | vga_gnt;
        ram_we    = (cpu_gnt && cpu_we) ? cpu_be : 4'b0000;
        ram_addr  = cpu_gnt ? cpu_addr : vga_addr;
        ram_wdata = cpu_wdata;
    end

    // The owner flag may still be set on the first reset cycle; mask it.
    assign cpu_rvalid = cpu_rd_q & ~reset;
    assign vga_rvalid = vga_rd_q & ~reset;
    assign cpu_rdata  = ram_rdata;
    assign vga_rdata  = ram_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 14, meaning word-address width of the shared RAM.
REQ-002 The module SHALL have parameter CPU_MAX_WAIT, default 4, meaning the maximum consecutive cycles a pending CPU request may be denied.
REQ-003 The module SHALL have a single clock port clk, and reset SHALL be synchronous and active-high on port reset.
REQ-004 The module SHALL have these ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  CPU data access request, held until granted
- cpu_we  in  1  1=store, 0=load
- cpu_be  in  4  byte enables for stores (sb/sh/sw)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  store data, lane-aligned
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  32  CPU load word; lbu/lb lane selection stays in the core
- vga_req  in  1  framebuffer fetch request, held until granted
- vga_addr  in  ADDR_W  framebuffer word address
- vga_gnt  out  1  VGA fetch issued this cycle
- vga_rvalid  out  1  VGA fetch data valid
- vga_rdata  out  32  VGA fetch word
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM per-byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, one cycle after ram_en with ram_we=0

Function
REQ-005 Arbitration SHALL be combinational within the request cycle, and at most one of cpu_gnt and vga_gnt SHALL be 1 in any cycle.
REQ-006 The default priority SHALL be VGA: with vga_req=1, vga_gnt=1 unless the arbiter is in state CPU_FORCE.
REQ-007 The arbiter SHALL have two states, VGA_PRI (reset state) and CPU_FORCE.
REQ-008 A wait counter SHALL increment each cycle that cpu_req=1 and cpu_gnt=0, saturating at CPU_MAX_WAIT, and SHALL clear on cpu_gnt=1 or cpu_req=0.
REQ-009 The next state SHALL be CPU_FORCE when the counter's next value equals CPU_MAX_WAIT, and VGA_PRI after any cycle with cpu_gnt=1.
REQ-010 In CPU_FORCE with cpu_req=1, cpu_gnt SHALL be 1 and vga_gnt SHALL be 0, regardless of vga_req.
REQ-011 With only one request asserted, that requester SHALL be granted in the same cycle in either state.
REQ-012 On a grant, ram_en SHALL be 1 and ram_addr SHALL be the granted address.
REQ-013 For a CPU store grant, ram_we SHALL be cpu_be and ram_wdata SHALL be cpu_wdata; for a CPU load or any VGA grant, ram_we SHALL be 4'b0000.
REQ-014 With no grant, ram_en SHALL be 0 and ram_we SHALL be 4'b0000.
REQ-015 Read latency SHALL be exactly one cycle: a registered owner flag SHALL assert cpu_rvalid or vga_rvalid in the cycle after a read grant, for exactly one cycle.
REQ-016 A CPU store SHALL produce no cpu_rvalid.
REQ-017 cpu_rdata and vga_rdata SHALL both equal ram_rdata, and SHALL be meaningful only when the corresponding rvalid=1.
REQ-018 Back-to-back grants SHALL be allowed every cycle, with no bubble between them.
REQ-019 A granted VGA read followed by a granted CPU read in the next cycle SHALL return vga_rvalid, then cpu_rvalid, in consecutive cycles.

Reset
REQ-020 While reset=1, cpu_gnt, vga_gnt, ram_en, cpu_rvalid and vga_rvalid SHALL be 0, and ram_we SHALL be 4'b0000.
REQ-021 Reset SHALL set the state to VGA_PRI and clear the wait counter and the owner flag.
REQ-022 A read granted in the cycle before reset asserts SHALL produce no rvalid.

Structure
REQ-023 The state encodings and the default CPU_MAX_WAIT SHALL live in the shared soc defines file.
REQ-024 The arbiter SHALL be one module with no sub-modules.
REQ-025 All flops SHALL use the existing dfflr-style register primitives.

Verification
REQ-026 The bench SHALL cover: CPU load only, cpu_addr=0x010 -> cpu_gnt same cycle; next cycle cpu_rvalid=1 and cpu_rdata=RAM[0x010].
REQ-027 The bench SHALL cover: CPU sb, cpu_be=4'b0100, wdata=0x00850000, addr=0x004 -> ram_we=4'b0100; only byte 2 of RAM[0x004] becomes 0x85; no cpu_rvalid.
REQ-028 The bench SHALL cover: vga_req held high and cpu_req raised at cycle 0 -> vga_gnt in cycles 0-3 and cpu_gnt in cycle 4 (CPU_MAX_WAIT=4); vga_gnt resumes in cycle 5.
REQ-029 The bench SHALL cover: alternating VGA grant then CPU grant -> vga_rvalid and cpu_rvalid in consecutive cycles with the correct words, never both 1.
REQ-030 The bench SHALL cover: reset asserted in the cycle after a CPU load grant -> no cpu_rvalid; state back in VGA_PRI; counter at 0.
REQ-031 The bench SHALL cover: no requests for 10 cycles -> ram_en=0 throughout.
